// File: rtl/apb_arb2_if.sv
// apb_arb2_if: the two requester command/response channels and the APB master bus of apb_arb2.
// The master modport is the arbiter's view; slave is the surrounding requesters and APB slave.
interface apb_arb2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0_valid, req0_ready, req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;

    logic              rsp0_valid, rsp0_slverr;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid, rsp1_slverr;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] paddr;
    logic              pwrite, psel, penable, pready, pslverr;
    logic [DATA_W-1:0] pwdata, prdata;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_slverr,
        output rsp1_valid, rsp1_rdata, rsp1_slverr,
        output paddr, pwrite, pwdata, psel, penable,
        input  pready, prdata, pslverr
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_slverr,
        input  rsp1_valid, rsp1_rdata, rsp1_slverr,
        input  paddr, pwrite, pwdata, psel, penable,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_arb2.sv
// apb_arb2: round-robin arbiter of two command requesters onto a single APB master port.
// Optional APB_ARB2_TIMEOUT_EN: abort an ACCESS phase after 16 cycles without pready (slverr=1).
module apb_arb2 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        aresetn,
    apb_arb2_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state, state_d;
    logic              grant0, grant1, done, timeout;
    logic              last_grant, owner;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q, rdata_q;
    logic              slverr_q, rsp0_q, rsp1_q;
`ifdef APB_ARB2_TIMEOUT_EN
    logic [3:0]        wait_cnt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        grant0  = 1'b0;
        grant1  = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                // last_grant=1 means req1 won last time, so req0 takes a tie.
                if (aresetn && (bus.req0_valid || bus.req1_valid)) begin
                    grant1  = bus.req1_valid && (!bus.req0_valid || !last_grant);
                    grant0  = !grant1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`ifdef APB_ARB2_TIMEOUT_EN
                else if (wait_cnt == 4'hF) begin
                    done    = 1'b1;
                    timeout = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= '0;
            rdata_q    <= '0;
            slverr_q   <= 1'b0;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
        end else begin
            rsp0_q <= done && !owner;
            rsp1_q <= done &&  owner;
            if (grant0 || grant1) begin
                owner      <= grant1;
                last_grant <= grant1;
                paddr_q    <= grant1 ? bus.req1_addr  : bus.req0_addr;
                pwrite_q   <= grant1 ? bus.req1_write : bus.req0_write;
                pwdata_q   <= grant1 ? bus.req1_wdata : bus.req0_wdata;
            end
            if (done) begin
                rdata_q  <= (timeout || pwrite_q) ? '0 : bus.prdata;
                slverr_q <= timeout || bus.pslverr;
            end
        end
    end

`ifdef APB_ARB2_TIMEOUT_EN
    // Cleared during SETUP so it reads zero on the first ACCESS cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)              wait_cnt <= '0;
        else if (state == SETUP)   wait_cnt <= '0;
        else if (state == ACCESS)  wait_cnt <= wait_cnt + 4'd1;
    end
`endif

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.psel        = (state != IDLE);
    assign bus.penable     = (state == ACCESS);
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp0_valid  = rsp0_q;
    assign bus.rsp1_valid  = rsp1_q;
    assign bus.rsp0_rdata  = rdata_q;
    assign bus.rsp1_rdata  = rdata_q;
    assign bus.rsp0_slverr = slverr_q;
    assign bus.rsp1_slverr = slverr_q;
endmodule

// File: tb/tb_apb_arb2.sv
// tb_apb_arb2: directed self-checking bench for apb_arb2 (timeout case only when APB_ARB2_TIMEOUT_EN is defined).
module tb_apb_arb2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic aresetn;
    int   n_checks = 0;
    int   n_errors = 0;

    apb_arb2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    apb_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1 ns after the rising edge and outputs checked 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer from the current (IDLE) cycle through its response cycle.
    task automatic xfer(input bit id, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input bit err, input string tag);
        logic [31:0] exp_rdata;
        exp_rdata = wr ? 32'h0 : rdata;
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wdata;
        end
        bus.pready = 1'b0;
        #1;
        check({tag, ".ready_own"},   id ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, ".ready_other"}, id ? bus.req0_ready : bus.req1_ready, 0);
        check({tag, ".accept_psel"}, bus.psel, 0);

        next_cycle();
        if (id == 1'b0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        #1;
        check({tag, ".setup_psel"},    bus.psel, 1);
        check({tag, ".setup_penable"}, bus.penable, 0);
        check({tag, ".setup_paddr"},   bus.paddr, addr);
        check({tag, ".setup_pwrite"},  bus.pwrite, wr);
        check({tag, ".setup_pwdata"},  bus.pwdata, wdata);

        for (int i = 0; i < waits; i++) begin
            next_cycle();
            #1;
            check({tag, ".wait_psel_penable"}, {bus.psel, bus.penable}, 2'b11);
            check({tag, ".wait_paddr"},        bus.paddr, addr);
            check({tag, ".wait_no_rsp"},       {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        end

        next_cycle();
        bus.pready = 1'b1; bus.prdata = rdata; bus.pslverr = err;
        #1;
        check({tag, ".access_psel_penable"}, {bus.psel, bus.penable}, 2'b11);
        check({tag, ".access_paddr"},        bus.paddr, addr);
        check({tag, ".access_pwdata"},       bus.pwdata, wdata);

        next_cycle();
        bus.pready = 1'b0; bus.prdata = 32'hBAD0_BAD0; bus.pslverr = 1'b0;
        #1;
        check({tag, ".rsp_valid_own"},   id ? bus.rsp1_valid : bus.rsp0_valid, 1);
        check({tag, ".rsp_valid_other"}, id ? bus.rsp0_valid : bus.rsp1_valid, 0);
        check({tag, ".rsp_rdata"},       id ? bus.rsp1_rdata : bus.rsp0_rdata, exp_rdata);
        check({tag, ".rsp_slverr"},      id ? bus.rsp1_slverr : bus.rsp0_slverr, err);
        check({tag, ".rsp_psel"},        bus.psel, 0);
    endtask

    initial begin
        aresetn        = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;

        // Reset state, with a request pending that must not be acknowledged.
        next_cycle();
        #1;
        check("rst.req0_ready", bus.req0_ready, 0);
        check("rst.psel_penable", {bus.psel, bus.penable}, 2'b00);
        check("rst.paddr", bus.paddr, 0);
        check("rst.pwrite", bus.pwrite, 0);
        check("rst.pwdata", bus.pwdata, 0);
        check("rst.rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        check("rst.rsp0_rdata", bus.rsp0_rdata, 0);
        check("rst.rsp_slverr", {bus.rsp0_slverr, bus.rsp1_slverr}, 2'b00);
        bus.req0_valid = 1'b0;
        next_cycle();
        aresetn = 1'b1;
        next_cycle();

        // Single write, zero wait states, then the response pulse must end.
        xfer(1'b0, 1'b1, 32'h10, 32'hA5, 0, 32'h0, 1'b0, "wr0");
        next_cycle();
        #1;
        check("wr0.rsp_pulse_end", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        check("wr0.idle_pwdata_hold", bus.pwdata, 32'hA5);

        // Re-reset so last-grant is req1 again, then three ties back to back.
        aresetn = 1'b0;
        next_cycle();
        aresetn = 1'b1;
        next_cycle();
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 32'h08;
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 0, 32'h1111_1111, 1'b0, "tie0");
        xfer(1'b1, 1'b0, 32'h08, 32'h0, 1, 32'h2222_2222, 1'b0, "tie1");
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 32'h08;
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 0, 32'h3333_3333, 1'b0, "tie2");
        bus.req1_valid = 1'b0;
        next_cycle();
        #1;
        check("tie2.no_extra_accept", {bus.psel, bus.req0_ready, bus.req1_ready}, 3'b000);

        // req1 read with 5 wait states and an error response.
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 5, 32'hDEAD_BEEF, 1'b1, "rd1_wait");

        // Reset in the middle of ACCESS aborts the transfer.
        next_cycle();
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = 32'h20; bus.req0_wdata = 32'h77;
        #1;
        check("abort.ready0", bus.req0_ready, 1);
        next_cycle();
        bus.req0_valid = 1'b0;
        next_cycle();
        #1;
        check("abort.in_access", {bus.psel, bus.penable}, 2'b11);
        aresetn = 1'b0;
        #1;
        check("abort.psel_penable_drop", {bus.psel, bus.penable}, 2'b00);
        check("abort.paddr_cleared", bus.paddr, 0);
        next_cycle();
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check("abort.no_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.psel}, 3'b000);
        end
        xfer(1'b1, 1'b1, 32'h30, 32'h99, 0, 32'h0, 1'b0, "post_rst");

`ifdef APB_ARB2_TIMEOUT_EN
        begin
            int access_cycles;
            access_cycles = 0;
            next_cycle();
            bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 32'h40; bus.req0_wdata = 32'h0;
            bus.pready = 1'b0; bus.prdata = 32'h5555_5555;
            #1;
            check("tmo.ready0", bus.req0_ready, 1);
            next_cycle();
            bus.req0_valid = 1'b0;
            for (int i = 0; i < 16; i++) begin
                next_cycle();
                #1;
                if (bus.psel && bus.penable && !bus.rsp0_valid) access_cycles++;
            end
            check("tmo.access_cycles", access_cycles, 16);
            next_cycle();
            #1;
            check("tmo.rsp0_valid", bus.rsp0_valid, 1);
            check("tmo.slverr", bus.rsp0_slverr, 1);
            check("tmo.rdata", bus.rsp0_rdata, 0);
            check("tmo.idle", {bus.psel, bus.penable}, 2'b00);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_arb2.md
APB_ARB2 -- requirements
Module: apb_arb2

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning APB/requester address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning APB/requester data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports: clk  in  1  clock, all logic on rising edge.
REQ-004 aresetn  in  1  asynchronous active-low reset.
REQ-005 req<i>_valid  in  1  requester i (i=0,1) has a pending APB command.
REQ-006 req<i>_ready  out  1  command of requester i accepted this cycle.
REQ-007 req<i>_write  in  1  1=write, 0=read.
REQ-008 req<i>_addr  in  ADDR_W  command address.
REQ-009 req<i>_wdata  in  DATA_W  write data.
REQ-010 rsp<i>_valid  out  1  one-cycle completion pulse to requester i.
REQ-011 rsp<i>_rdata  out  DATA_W  read data, valid with rsp<i>_valid.
REQ-012 rsp<i>_slverr  out  1  error status, valid with rsp<i>_valid.
REQ-013 paddr, pwrite, pwdata  out  ADDR_W/1/DATA_W  APB master address/direction/write data to array_alu.
REQ-014 psel, penable  out  1  APB master select/enable.
REQ-015 pready, prdata, pslverr  in  1/DATA_W/1  APB slave response.

Function
REQ-016 FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-017 IDLE: if any req<i>_valid, SHALL assert req<i>_ready combinationally for exactly one granted requester, latch write/addr/wdata, go SETUP.
REQ-018 Both valid in IDLE: grant SHALL go to the requester not granted last (round-robin); after reset req0 wins first tie.
REQ-019 SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS.
REQ-020 ACCESS: psel=1, penable=1, held until pready=1 sampled; then IDLE.
REQ-021 paddr/pwrite/pwdata SHALL be stable from SETUP through last ACCESS cycle; outside transfers psel=penable=0 and paddr/pwrite/pwdata hold last value.
REQ-022 Cycle after pready sampled, rsp<i>_valid SHALL pulse 1 cycle for granted requester with rdata=captured prdata (0 for writes), slverr=captured pslverr.
REQ-023 Latency: accept at T -> psel T+1 -> penable T+2 -> rsp_valid earliest T+3; next accept earliest T+3 (max 1 transfer / 3 cycles).
REQ-024 Requesters SHALL hold valid and payload until ready; block ignores valid outside IDLE; no response backpressure.
REQ-025 req<i>_ready and rsp<i>_valid SHALL never be asserted for both requesters in the same cycle.

Reset
REQ-026 aresetn=0 SHALL immediately force state IDLE, psel=penable=0, req<i>_ready=0, rsp<i>_valid=0, rsp<i>_rdata=0, rsp<i>_slverr=0, paddr=pwdata=0, pwrite=0, last-grant=req1.
REQ-027 Reset during SETUP/ACCESS SHALL abort the transfer; no response for it after reset release.

Configuration
REQ-028 Macro APB_ARB2_TIMEOUT_EN defined: 4-bit counter clears on ACCESS entry; 16 ACCESS cycles without pready SHALL end transfer (psel=penable=0, IDLE) and pulse rsp<i>_valid with slverr=1, rdata=0.
REQ-029 Macro undefined: no counter; ACCESS SHALL wait for pready indefinitely.

Verification
REQ-030 req0 write addr 0x10 data 0xA5, pready=1 immediately -> psel T+1, penable T+2, rsp0_valid T+3, slverr=0.
REQ-031 req0 and req1 valid together, reads of 0x04/0x08 -> req0 served first, then req1; third tie after that goes to req0.
REQ-032 req1 read 0x0C, pready after 5 wait cycles, prdata 0xDEADBEEF, pslverr=1 -> paddr stable all cycles, rsp1_rdata=0xDEADBEEF, slverr=1.
REQ-033 aresetn low during ACCESS (as at cycle 1000 of array_alu bench) -> psel/penable drop same cycle, no rsp pulse, new request accepted after release.
REQ-034 APB_ARB2_TIMEOUT_EN defined, pready tied 0 -> after 16 ACCESS cycles rsp0_valid with slverr=1, rdata=0, FSM IDLE.
